// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
//   Shared constants and types for the CRC link (transmitter and checker).
//   Default configuration is CRC-3 over 4-bit data with generator x^3+x+1,
//   i.e. a systematic (7,4) cyclic code.
//
//   Contents:
//     BW, CRC_BW, POLY : default data width, remainder width, generator
//     CW               : codeword width (BW + CRC_BW)
//     data_t, rem_t, codeword_t : default-width vector types
//     poly_is_valid()  : checks that a generator has x^n and x^0 terms set
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package crc_pkg;

    localparam int BW     = 4;
    localparam int CRC_BW = 3;
    localparam int CW     = BW + CRC_BW;

    // Generator, MSB first, CRC_BW+1 bits (x^3 + x + 1).
    localparam logic [CRC_BW:0] POLY = 4'b1011;

    typedef logic [BW-1:0]     data_t;
    typedef logic [CRC_BW-1:0] rem_t;
    typedef logic [CW-1:0]     codeword_t;

    // A usable generator must have both its leading and constant term set;
    // without x^0 the code would just be a shifted copy of a shorter one.
    function automatic logic poly_is_valid(input logic [CRC_BW:0] p);
        return p[CRC_BW] & p[0];
    endfunction

endpackage : crc_pkg

// File: rtl/crc_remainder.sv
// ---------------------------------------------------------------------------
// crc_remainder
//   Purely combinational CRC remainder generator:
//     rem = (data * x^CRC_BW) mod POLY over GF(2)
//   Implemented as a BW-iteration bitwise shift/XOR loop, MSB first, with an
//   initial remainder of zero, so every word is encoded independently.
//   Shared by the transmitter (encoding) and the receiver (checking).
//
//   Parameters:
//     BW     : data width
//     CRC_BW : remainder width (generator degree)
//     POLY   : generator, CRC_BW+1 bits, MSB first
//
//   Ports:
//     data   : input  [BW-1:0]     word to encode
//     rem    : output [CRC_BW-1:0] remainder
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module crc_remainder
    import crc_pkg::*;
#(
    parameter int                BW     = crc_pkg::BW,
    parameter int                CRC_BW = crc_pkg::CRC_BW,
    parameter logic [CRC_BW:0]   POLY   = crc_pkg::POLY
) (
    input  logic [BW-1:0]     data,
    output logic [CRC_BW-1:0] rem
);

    // The leading term is implicit: it is exactly the bit shifted out of the
    // remainder register, so only the lower CRC_BW bits are ever XORed in.
    localparam logic [CRC_BW-1:0] POLY_LOW = POLY[CRC_BW-1:0];

    logic [CRC_BW-1:0] rem_v;
    logic              fb;

    always_comb begin
        rem_v = '0;
        fb    = 1'b0;
        for (int i = BW - 1; i >= 0; i--) begin
            // Feeding the data bit in at the top is equivalent to long
            // division of {data, CRC_BW zeros} by POLY.
            fb    = data[i] ^ rem_v[CRC_BW-1];
            rem_v = rem_v << 1;
            if (fb) begin
                rem_v = rem_v ^ POLY_LOW;
            end
        end
        rem = rem_v;
    end

endmodule : crc_remainder

// File: rtl/crc_transmitter.sv
// ---------------------------------------------------------------------------
// crc_transmitter
//   Transmit-side CRC encoder. Every rising edge it captures one data word
//   and registers the systematic codeword {data, remainder}. Full
//   throughput, one-cycle latency, no handshake.
//
//   Parameters:
//     BW, CRC_BW, POLY : see crc_remainder
//
//   Ports:
//     clk  : input                  system clock, rising-edge active
//     rstn : input                  asynchronous active-low reset
//     in   : input  [BW-1:0]        data word, sampled every rising edge
//     out  : output [BW+CRC_BW-1:0] registered codeword
//                                   out[BW+CRC_BW-1:CRC_BW] = data
//                                   out[CRC_BW-1:0]         = remainder
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module crc_transmitter
    import crc_pkg::*;
#(
    parameter int              BW     = crc_pkg::BW,
    parameter int              CRC_BW = crc_pkg::CRC_BW,
    parameter logic [CRC_BW:0] POLY   = crc_pkg::POLY
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [BW-1:0]          in,
    output logic [BW+CRC_BW-1:0]   out
);

    localparam int CW_W = BW + CRC_BW;

    logic [CRC_BW-1:0] rem_w;
    logic [CW_W-1:0]   out_d;
    logic [CW_W-1:0]   out_q;

    crc_remainder #(
        .BW     (BW),
        .CRC_BW (CRC_BW),
        .POLY   (POLY)
    ) u_rem (
        .data (in),
        .rem  (rem_w)
    );

    assign out_d = {in, rem_w};

    // The codeword register is the only state. All-zero on reset is also
    // the legal codeword of data 0, so the link sees a valid word at once.
    // Because nothing else is stored, an X word cannot leak into the next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : crc_transmitter

// File: tb/tb_crc_transmitter.sv
`timescale 1ns/1ps

module tb_crc_transmitter;

    logic       clk;
    logic       rstn;
    logic [3:0] din;
    logic [6:0] dout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] sb[$];
    logic [6:0] obs_tbl[16];

    crc_transmitter dut (
        .clk  (clk),
        .rstn (rstn),
        .in   (din),
        .out  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent reference: long division on the whole 7-bit dividend.
    function automatic logic [6:0] golden(input logic [3:0] d);
        logic [6:0] v;
        logic [6:0] p;
        v = {d, 3'b000};
        p = 7'b0001011;
        for (int b = 6; b >= 3; b--) begin
            if (v[b]) v = v ^ (p << (b - 3));
        end
        return {d, v[2:0]};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, push expectation, compare 1ns after the
    // capturing rising edge. One call consumes exactly one clock cycle.
    task automatic send(input logic [3:0] d, input string tag, output logic [6:0] got);
        logic [6:0] exp;
        @(negedge clk);
        din = d;
        sb.push_back(golden(d));
        @(posedge clk);
        #1;
        got = dout;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed %h expected scoreboard entry, queue empty", tag, dout);
        end else begin
            exp = sb.pop_front();
            check(tag, dout, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    logic [6:0] got;
    logic [3:0] vec_in  [5];
    logic [6:0] vec_out [5];

    initial begin
        vec_in  = '{4'h0, 4'h1, 4'h5, 4'h8, 4'hF};
        vec_out = '{7'h00, 7'h0B, 7'h2C, 7'h45, 7'h7F};

        // Post-reset recovery: release at t=12, between edges.
        rstn = 1'b0;
        din  = 4'h1;
        #3;
        check("reset_t3", dout, 7'h00);
        #5;                                 // t=8, after edge at t=5
        check("reset_edge5", dout, 7'h00);
        #4;                                 // t=12
        rstn = 1'b1;
        @(posedge clk);                     // t=15, first edge with rstn high
        #1;
        check("recovery_first_edge", dout, 7'h0B);

        // Asynchronous assertion between edges, then hold with in toggling.
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("async_clear", dout, 7'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = (i % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
            check("reset_hold", dout, 7'h00);
        end
        @(negedge clk);
        rstn = 1'b1;

        // Directed single-word vectors.
        for (int i = 0; i < 5; i++) begin
            send(vec_in[i], "vector_model", got);
            check("vector_const", got, vec_out[i]);
        end

        // Exhaustive back-to-back, no bubbles.
        for (int d = 0; d < 16; d++) begin
            send(4'(d), "exhaustive", got);
            obs_tbl[d] = got;
        end

        // Linearity over all pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                check("linearity", obs_tbl[a] ^ obs_tbl[b], obs_tbl[a ^ b]);
            end
        end
        check("linearity_1_8", obs_tbl[1] ^ obs_tbl[8], 7'h4E);

        // Random stream.
        for (int i = 0; i < 100; i++) begin
            send(4'($urandom_range(0, 15)), "random", got);
        end

        // X word followed by a clean word.
        @(negedge clk);
        din = 4'bxxxx;
        send(4'h3, "after_x", got);

        // Reset mid-stream discards the pending word.
        send(4'hC, "pre_reset", got);
        @(negedge clk);
        din = 4'h6;
        #2;
        rstn = 1'b0;
        #1;
        check("midstream_clear", dout, 7'h00);
        @(posedge clk);
        #1;
        check("midstream_hold", dout, 7'h00);
        @(negedge clk);
        rstn = 1'b1;
        send(4'hA, "post_midstream", got);
        check("post_midstream_const", got, 7'h53);

        check("scoreboard_empty", 7'(sb.size()), 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_crc_transmitter
